// File: rtl/demux_pkg.sv
// Shared types and helpers for the registered 1-to-4 stream demultiplexer.
package demux_pkg;

    typedef logic [1:0] sel_t;

    localparam int NUM_OUT = 4;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    function automatic logic [NUM_OUT-1:0] sel_decode(input sel_t sel);
        logic [NUM_OUT-1:0] onehot;
        onehot      = {NUM_OUT{1'b0}};
        onehot[sel] = 1'b1;
        return onehot;
    endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry output slot: holds a word until its consumer takes it and counts
// completed handshakes on this output.
module demux_slot
    import demux_pkg::*;
#(
    parameter int N     = 64,
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [N-1:0]     i_data,
    input  logic             i_ready,
    input  logic             i_clr,
    output logic             o_valid,
    output logic [N-1:0]     o_data,
    output logic [CNT_W-1:0] o_cnt
);

    slot_state_e      state_r;
    slot_state_e      state_s;
    logic [N-1:0]     data_r;
    logic [CNT_W-1:0] cnt_r;
    logic             drain_s;

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= SLOT_EMPTY;
        end else begin
            state_r <= state_s;
        end
    end

    // Next state: a load always leaves the slot full, even when it drains on the same edge.
    always_comb begin
        state_s = state_r;
        case (state_r)
            SLOT_EMPTY: begin
                if (i_load) begin
                    state_s = SLOT_FULL;
                end else begin
                    state_s = SLOT_EMPTY;
                end
            end
            SLOT_FULL: begin
                if (i_ready && !i_load) begin
                    state_s = SLOT_EMPTY;
                end else begin
                    state_s = SLOT_FULL;
                end
            end
            default: begin
                state_s = SLOT_EMPTY;
            end
        endcase
    end

    // Output decode: a handshake completes whenever a full slot sees ready.
    always_comb begin
        drain_s = 1'b0;
        case (state_r)
            SLOT_FULL:  drain_s = i_ready;
            SLOT_EMPTY: drain_s = 1'b0;
            default:    drain_s = 1'b0;
        endcase
    end

    // Slot data register; holds its word until a new load replaces it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            data_r <= {N{1'b0}};
        end else if (i_load) begin
            data_r <= i_data;
        end else begin
            data_r <= data_r;
        end
    end

    // Delivered-word counter; clear wins over a same-cycle increment, wraps naturally.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (i_clr) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (drain_s) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign o_valid = (state_r == SLOT_FULL);
    assign o_data  = data_r;
    assign o_cnt   = cnt_r;

endmodule

// File: rtl/demux_4_reg.sv
// Registered 1-to-4 stream demultiplexer: routes each accepted word into one of
// four one-entry output slots selected by i_s.
module demux_4_reg
    import demux_pkg::*;
#(
    parameter int N     = 64,
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [N-1:0]     i_data,
    input  logic [1:0]       i_s,
    output logic [3:0]       o_valid,
    input  logic [3:0]       i_ready,
    output logic [N-1:0]     o_data0,
    output logic [N-1:0]     o_data1,
    output logic [N-1:0]     o_data2,
    output logic [N-1:0]     o_data3,
    output logic [CNT_W-1:0] o_cnt0,
    output logic [CNT_W-1:0] o_cnt1,
    output logic [CNT_W-1:0] o_cnt2,
    output logic [CNT_W-1:0] o_cnt3,
    input  logic             i_clr_cnt
);

    sel_t               sel_s;
    logic [NUM_OUT-1:0] sel_oh_s;
    logic [NUM_OUT-1:0] load_s;
    logic [NUM_OUT-1:0] valid_s;
    logic               ready_s;
    logic [N-1:0]       data_s [NUM_OUT];
    logic [CNT_W-1:0]   cnt_s  [NUM_OUT];

    assign sel_s = i_s;

    // Ready mux and load decode; ready depends only on slot state and consumer ready, never on i_valid.
    always_comb begin
        sel_oh_s = sel_decode(sel_s);
        if (!i_rst_n) begin
            ready_s = 1'b0;
        end else begin
            ready_s = !valid_s[sel_s] || i_ready[sel_s];
        end
        if (i_valid && ready_s) begin
            load_s = sel_oh_s;
        end else begin
            load_s = {NUM_OUT{1'b0}};
        end
    end

    for (genvar k = 0; k < NUM_OUT; k++) begin : g_slot
        demux_slot #(
            .N     (N),
            .CNT_W (CNT_W)
        ) u_slot (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_load  (load_s[k]),
            .i_data  (i_data),
            .i_ready (i_ready[k]),
            .i_clr   (i_clr_cnt),
            .o_valid (valid_s[k]),
            .o_data  (data_s[k]),
            .o_cnt   (cnt_s[k])
        );
    end

    assign o_ready = ready_s;
    assign o_valid = valid_s;
    assign o_data0 = data_s[0];
    assign o_data1 = data_s[1];
    assign o_data2 = data_s[2];
    assign o_data3 = data_s[3];
    assign o_cnt0  = cnt_s[0];
    assign o_cnt1  = cnt_s[1];
    assign o_cnt2  = cnt_s[2];
    assign o_cnt3  = cnt_s[3];

endmodule

// File: tb/tb_demux_4_reg.sv
// Self-checking bench for demux_4_reg: a slot/counter scoreboard checked every
// cycle, a routing vector table and hand-written corner-case sequences.
module tb_demux_4_reg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_valid;
    logic [63:0] i_data;
    logic [1:0]  i_s;
    logic [3:0]  i_ready;
    logic        i_clr_cnt;

    logic        o_ready;
    logic [3:0]  o_valid;
    logic [63:0] od [4];
    logic [15:0] oc [4];

    logic        w_ready;
    logic [3:0]  w_valid;
    logic [63:0] wd [4];
    logic [3:0]  wc [4];

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    demux_4_reg #(.N(64), .CNT_W(16)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_data(i_data), .i_s(i_s), .o_valid(o_valid), .i_ready(i_ready),
        .o_data0(od[0]), .o_data1(od[1]), .o_data2(od[2]), .o_data3(od[3]),
        .o_cnt0(oc[0]), .o_cnt1(oc[1]), .o_cnt2(oc[2]), .o_cnt3(oc[3]),
        .i_clr_cnt(i_clr_cnt)
    );

    // Narrow-counter copy on the same stimulus, used to reach counter wrap quickly.
    demux_4_reg #(.N(64), .CNT_W(4)) dut_w (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(w_ready),
        .i_data(i_data), .i_s(i_s), .o_valid(w_valid), .i_ready(i_ready),
        .o_data0(wd[0]), .o_data1(wd[1]), .o_data2(wd[2]), .o_data3(wd[3]),
        .o_cnt0(wc[0]), .o_cnt1(wc[1]), .o_cnt2(wc[2]), .o_cnt3(wc[3]),
        .i_clr_cnt(i_clr_cnt)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_counters();
        step();
        i_clr_cnt = 1'b1;
        step();
        i_clr_cnt = 1'b0;
    endtask

    task automatic send_burst(input logic [1:0] s, input int n, input logic [63:0] base);
        for (int j = 0; j < n; j++) begin
            step();
            i_valid = 1'b1;
            i_s     = s;
            i_data  = base + 64'(j);
        end
        step();
        i_valid = 1'b0;
        step();
    endtask

    // Scoreboard: one queue per slot plus a model counter per output
    logic [63:0] sbq [4][$];
    logic [15:0] cnt_m [4];

    always @(negedge clk) begin
        logic       exp_rdy;
        logic [3:0] exp_v;
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) begin
                sbq[k].delete();
                cnt_m[k] = 16'd0;
            end
        end
        for (int k = 0; k < 4; k++) exp_v[k] = (sbq[k].size() != 0);
        exp_rdy = rst_n && (!exp_v[i_s] || i_ready[i_s]);
        check("o_ready", {63'd0, o_ready}, {63'd0, exp_rdy});
        check("w_ready", {63'd0, w_ready}, {63'd0, exp_rdy});
        check("o_valid", {60'd0, o_valid}, {60'd0, exp_v});
        check("w_valid", {60'd0, w_valid}, {60'd0, exp_v});
        for (int k = 0; k < 4; k++) begin
            if (exp_v[k]) begin
                check($sformatf("o_data%0d", k), od[k], sbq[k][0]);
                check($sformatf("w_data%0d", k), wd[k], sbq[k][0]);
            end
            check($sformatf("o_cnt%0d", k), {48'd0, oc[k]}, {48'd0, cnt_m[k]});
            check($sformatf("w_cnt%0d", k), {60'd0, wc[k]}, {60'd0, cnt_m[k][3:0]});
        end
        if (rst_n) begin
            for (int k = 0; k < 4; k++) begin
                if (exp_v[k] && i_ready[k]) begin
                    void'(sbq[k].pop_front());
                    cnt_m[k] = cnt_m[k] + 16'd1;
                end
                if (i_clr_cnt) cnt_m[k] = 16'd0;
            end
            if (i_valid && exp_rdy) sbq[i_s].push_back(i_data);
        end
    end

    typedef struct {
        logic [1:0]  s;
        logic [63:0] d;
        logic [3:0]  exp_v;
    } vec_t;

    vec_t vt [4];

    initial begin
        rst_n     = 1'b1;
        i_valid   = 1'b0;
        i_data    = 64'd0;
        i_s       = 2'd0;
        i_ready   = 4'b0000;
        i_clr_cnt = 1'b0;
        for (int i = 0; i < 4; i++) begin
            vt[i].s     = 2'(i);
            vt[i].d     = 64'hA0 + 64'(i);
            vt[i].exp_v = 4'b0001 << i;
        end

        // Reset with a pending valid
        #2;
        rst_n   = 1'b0;
        i_valid = 1'b1;
        i_s     = 2'd1;
        i_data  = 64'hDEAD;
        repeat (3) @(negedge clk);
        check("rst_ready", {63'd0, o_ready}, 64'd0);
        check("rst_valid", {60'd0, o_valid}, 64'd0);
        for (int k = 0; k < 4; k++) begin
            check("rst_cnt", {48'd0, oc[k]}, 64'd0);
            check("rst_data", od[k], 64'd0);
        end
        step();
        i_valid = 1'b0;
        rst_n   = 1'b1;
        #1;
        check("rel_ready", {63'd0, o_ready}, 64'd1);

        // Routing table
        i_ready = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            step();
            i_valid = 1'b1;
            i_s     = vt[i].s;
            i_data  = vt[i].d;
            step();
            i_valid = 1'b0;
            @(negedge clk);
            check("route_valid", {60'd0, o_valid}, {60'd0, vt[i].exp_v});
            check("route_data", od[vt[i].s], vt[i].d);
        end
        step();
        @(negedge clk);
        for (int k = 0; k < 4; k++) check("route_cnt", {48'd0, oc[k]}, 64'd1);

        // Backpressure on slot 2
        clear_counters();
        i_ready = 4'b1011;
        i_valid = 1'b1;
        i_s     = 2'd2;
        i_data  = 64'h11;
        step();
        i_data  = 64'h22;
        @(negedge clk);
        check("bp_ready", {63'd0, o_ready}, 64'd0);
        check("bp_hold", od[2], 64'h11);
        step();
        step();
        @(negedge clk);
        check("bp_hold2", od[2], 64'h11);
        check("bp_ready2", {63'd0, o_ready}, 64'd0);
        step();
        i_ready = 4'b1111;
        #1;
        check("bp_release", {63'd0, o_ready}, 64'd1);
        step();
        i_valid = 1'b0;
        @(negedge clk);
        check("bp_new", od[2], 64'h22);
        check("bp_valid", {63'd0, o_valid[2]}, 64'd1);
        check("bp_cnt", {48'd0, oc[2]}, 64'd1);
        step();
        @(negedge clk);
        check("bp_cnt2", {48'd0, oc[2]}, 64'd2);
        check("bp_empty", {63'd0, o_valid[2]}, 64'd0);

        // Full throughput into one output
        clear_counters();
        for (int j = 0; j < 100; j++) begin
            step();
            i_valid = 1'b1;
            i_s     = 2'd1;
            i_data  = 64'h1000 + 64'(j);
            @(negedge clk);
            check("tput_ready", {63'd0, o_ready}, 64'd1);
        end
        step();
        i_valid = 1'b0;
        step();
        @(negedge clk);
        check("tput_cnt", {48'd0, oc[1]}, 64'd100);

        // Counter wrap on the 4-bit copy, then clear during a drain
        clear_counters();
        send_burst(2'd0, 15, 64'h5000);
        @(negedge clk);
        check("wrap_pre", {60'd0, wc[0]}, 64'hF);
        send_burst(2'd0, 2, 64'h6000);
        @(negedge clk);
        check("wrap_cnt", {60'd0, wc[0]}, 64'd1);
        check("wrap_wide", {48'd0, oc[0]}, 64'd17);
        step();
        i_valid = 1'b1;
        i_s     = 2'd0;
        i_data  = 64'h7000;
        step();
        i_valid   = 1'b0;
        i_clr_cnt = 1'b1;
        step();
        i_clr_cnt = 1'b0;
        @(negedge clk);
        check("clr_drain_w", {60'd0, wc[0]}, 64'd0);
        check("clr_drain", {48'd0, oc[0]}, 64'd0);

        // Asynchronous reset with slots 0 and 3 full
        i_ready = 4'b0110;
        step();
        i_valid = 1'b1;
        i_s     = 2'd0;
        i_data  = 64'hC0;
        step();
        i_s     = 2'd3;
        i_data  = 64'hC3;
        step();
        i_valid = 1'b0;
        @(negedge clk);
        check("mid_full", {60'd0, o_valid}, 64'h9);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", {60'd0, o_valid}, 64'd0);
        check("mid_rst_ready", {63'd0, o_ready}, 64'd0);
        step();
        step();
        rst_n   = 1'b1;
        i_ready = 4'b1111;
        repeat (3) step();
        @(negedge clk);
        check("mid_post_valid", {60'd0, o_valid}, 64'd0);
        check("mid_post_cnt0", {48'd0, oc[0]}, 64'd0);
        check("mid_post_cnt3", {48'd0, oc[3]}, 64'd0);

        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
